regfile_multiport: RTL
======================

# regfile_multiport

Parametrised general-purpose register file for the pipelined CPU, successor to the single-write 32×32 file. It provides a configurable number of combinational read ports, two write ports with fixed priority, same-cycle write-to-read bypass, and a per-register busy scoreboard that decode uses for hazard stalls. It sits between decode (reads and issue) and writeback (writes).

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports, legal range 1..4
- CLK  in  1  clock; all state updates on posedge
- RESET  in  1  synchronous, active-high reset
- WE0  in  1  write enable, port 0 (older instruction)
- WA0  in  ADDR_W  write address, port 0
- WD0  in  DATA_W  write data, port 0
- PC0  in  32  PC of the writing instruction, port 0 (trace only)
- WE1, WA1, WD1, PC1  same as port 0, for port 1 (younger instruction)
- RA  in  NUM_RD*ADDR_W  packed read addresses; port k = RA[k*ADDR_W +: ADDR_W]
- RD  out  NUM_RD*DATA_W  packed read data
- RBUSY  out  NUM_RD  busy flag of each read address
- ISSUE_EN  in  1  marks ISSUE_A busy (destination of a newly issued instruction)
- ISSUE_A  in  ADDR_W  destination register being issued
- FLUSH  in  1  clears all busy bits (pipeline flush)

## Operation
- Register 0 is hardwired zero: writes to it are dropped, reads return 0, it is never busy, and an issue to it is ignored.
- Write: on posedge, if WEn is high and WAn != 0, then reg[WAn] <= WDn.
- If both ports are enabled with equal non-zero addresses, only port 1's write lands.
- Read: RD[k] is combinational.
  - If RA[k] == 0, RD[k] is 0.
  - Else, if WE1 is high and WA1 == RA[k], RD[k] = WD1.
  - Else, if WE0 is high and WA0 == RA[k], RD[k] = WD0.
  - Else RD[k] = reg[RA[k]].
- Scoreboard: one busy bit per register.
  - Next busy[a] = ISSUE_EN && ISSUE_A == a, OR (busy[a] AND NOT (a written this cycle) AND NOT FLUSH).
  - Issue beats a same-cycle write or FLUSH on the same address: the new producer stays outstanding.
  - A write clears busy regardless of which port performs it.
- RBUSY[k] is combinational: busy[RA[k]] AND NOT (a write to RA[k] this cycle). A same-cycle writeback therefore shows not-busy, consistent with the bypassed data. RBUSY[k] is 0 when RA[k] == 0.
- RESET clears all registers and all busy bits. It overrides writes, issue and FLUSH in the same cycle.

## Timing
- Read latency: 0 cycles (combinational). Write becomes visible in storage 1 cycle after the edge, and to readers in the same cycle via bypass.
- Busy set by ISSUE_EN at edge t is visible on RBUSY from t+1.
- Reset values:
  - all registers are 0;
  - all busy bits are 0;
  - RD and RBUSY follow combinationally from those values and the current inputs.
- Initial (pre-reset) state is also all zero in simulation.
- Reset asserted mid-stream discards any pending write that cycle. The first post-reset edge accepts writes normally.
- No handshake: every enabled write is accepted and the block never stalls. Hazard stalling is the decoder's job, based on RBUSY.

## Configuration
- Macro: RF_TRACE_EN.
- Defined: every write that lands in storage prints "%d@%h: $%d <= %h" with $time, PCn, WAn and WDn.
  - If both ports land on different addresses, port 0's line is printed before port 1's.
  - Dropped writes print nothing: address 0, the losing port of a collision, and writes during reset.
- Undefined: no $display statements are compiled; all functional behaviour is identical.

## Test plan
- Reset then read all addresses -> RD = 0 and RBUSY = 0 everywhere. Write WA0=5, WD0=0x1234 -> the next cycle reads 0x1234 from RA=5.
- Same-cycle bypass: WE0, WA0=7, WD0=0xAAAA with RA[1]=7 -> RD[1]=0xAAAA in that cycle; the value persists afterwards.
- Collision: WE0 and WE1 both at address 3, WD0=0x11, WD1=0x22 -> reg[3]=0x22. With the trace on, exactly one line is printed, with PC1.
- Write to address 0 with WD=0xFFFFFFFF -> reads return 0, no trace line, RBUSY[0]=0. ISSUE_A=0 also leaves it not-busy.
- Scoreboard:
  - issue to 9 -> RBUSY=1 for RA=9;
  - a write to 9 in a later cycle -> RBUSY=0 in the same cycle;
  - issue plus write to 9 in the same cycle -> stays busy;
  - FLUSH -> all busy bits cleared.
- RESET asserted together with WE0 (address 4, 0x55) and ISSUE_EN (address 4) -> reg[4]=0 and not busy afterwards, no trace line.

Source files
------------

// File: rtl/regfile_multiport.sv
// rtl/regfile_multiport.sv - multiport register file with write bypass and busy scoreboard
// Optional write trace compiled in when RF_TRACE_EN is defined.
module regfile_multiport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     WE0,
  input  logic [ADDR_W-1:0]        WA0,
  input  logic [DATA_W-1:0]        WD0,
  input  logic [31:0]              PC0,
  input  logic                     WE1,
  input  logic [ADDR_W-1:0]        WA1,
  input  logic [DATA_W-1:0]        WD1,
  input  logic [31:0]              PC1,
  input  logic [NUM_RD*ADDR_W-1:0] RA,
  output logic [NUM_RD*DATA_W-1:0] RD,
  output logic [NUM_RD-1:0]        RBUSY,
  input  logic                     ISSUE_EN,
  input  logic [ADDR_W-1:0]        ISSUE_A,
  input  logic                     FLUSH
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [DEPTH-1:0]  wr_hit;
  logic              we0_ok;
  logic              we1_ok;

  // Port 0 loses a same-address collision so only the younger write lands.
  assign we1_ok = WE1 && (WA1 != '0);
  assign we0_ok = WE0 && (WA0 != '0) && !(WE1 && (WA1 == WA0));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (we0_ok) regs[WA0] <= WD0;
      if (we1_ok) regs[WA1] <= WD1;
    end
  end

  // Issue wins over a same-cycle write or flush: the new producer is outstanding.
  always_comb begin
    busy_nxt = '0;
    wr_hit   = '0;
    for (int a = 1; a < DEPTH; a++) begin
      wr_hit[a]   = (WE0 && (WA0 == ADDR_W'(a))) || (WE1 && (WA1 == ADDR_W'(a)));
      busy_nxt[a] = (ISSUE_EN && (ISSUE_A == ADDR_W'(a))) ||
                    (busy[a] && !wr_hit[a] && !FLUSH);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) busy <= '0;
    else       busy <= busy_nxt;
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = RA[k*ADDR_W +: ADDR_W];
    assign RD[k*DATA_W +: DATA_W] = (ra == '0)                 ? '0  :
                                    (WE1 && (WA1 == ra))       ? WD1 :
                                    (WE0 && (WA0 == ra))       ? WD0 :
                                                                 regs[ra];
    assign RBUSY[k] = (ra != '0) && busy[ra] && !wr_hit[ra];
  end

`ifdef RF_TRACE_EN
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (we0_ok) $display("%d@%h: $%d <= %h", $time, PC0, WA0, WD0);
      if (we1_ok) $display("%d@%h: $%d <= %h", $time, PC1, WA1, WD1);
    end
  end
`else
  logic unused_pc;
  assign unused_pc = ^{PC0, PC1};
`endif

endmodule
